bp_be_dcache_replay_ctrl: RTL

Parametrised multi-channel replay controller between a packet source (trace replayer or BE issue model) and `N` `bp_be_dcache` instances. Each channel buffers dcache packets with their physical tags, issues them in order, checkpoints on dcache completion and rewinds to the oldest uncompleted packet on a cache miss. A per-channel registered mock-TLB stage presents the ptag one cycle after issue and can inject periodic TLB misses to exercise the rollback path. It generalises the single-depth, fixed-channel rolly-FIFO-plus-mock-TLB arrangement with configurable channel count and depth, miss injection and replay statistics.

---
 rtl/bp_be_dcache_replay_ctrl_pkg.sv | 36 +++
 rtl/bp_be_replay_fifo.sv | 115 +++++++++++
 rtl/bp_be_dcache_replay_ctrl.sv | 52 +++++
 3 files changed

// File: rtl/bp_be_dcache_replay_ctrl_pkg.sv
// Shared types and widths for the dcache replay controller: the dcache packet
// layout, the physical tag width and the saturating replay-counter helper.
package bp_be_dcache_replay_ctrl_pkg;

  localparam int unsigned paddr_width_gp          = 40;
  localparam int unsigned bp_page_offset_width_gp = 12;
  localparam int unsigned dword_width_gp          = 64;
  localparam int unsigned ptag_width_gp           = paddr_width_gp - bp_page_offset_width_gp;
  localparam int unsigned replay_cnt_width_gp     = 16;

  typedef enum logic [4:0] {
    e_dcache_op_lb = 5'h00,
    e_dcache_op_lh = 5'h01,
    e_dcache_op_lw = 5'h02,
    e_dcache_op_ld = 5'h03,
    e_dcache_op_sb = 5'h08,
    e_dcache_op_sh = 5'h09,
    e_dcache_op_sw = 5'h0a,
    e_dcache_op_sd = 5'h0b
  } bp_be_dcache_opcode_e;

  typedef struct packed {
    bp_be_dcache_opcode_e                 opcode;
    logic [bp_page_offset_width_gp-1:0]   page_offset;
    logic [dword_width_gp-1:0]            data;
  } bp_be_dcache_pkt_s;

  localparam int unsigned dcache_pkt_width_gp = $bits(bp_be_dcache_pkt_s);

  function automatic logic [replay_cnt_width_gp-1:0] sat_inc(
    input logic [replay_cnt_width_gp-1:0] x
  );
    return (x == '1) ? x : x + replay_cnt_width_gp'(1);
  endfunction

endpackage

// File: rtl/bp_be_replay_fifo.sv
// One replay channel: rolly FIFO with write/read/checkpoint pointers, a
// registered mock-TLB stage with periodic miss injection, and a replay counter.
module bp_be_replay_fifo
  import bp_be_dcache_replay_ctrl_pkg::*;
#(
  parameter int unsigned els_p             = 8,
  parameter int unsigned pkt_width_p       = dcache_pkt_width_gp,
  parameter int unsigned ptag_width_p      = ptag_width_gp,
  parameter int unsigned tlb_miss_period_p = 0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [pkt_width_p-1:0]         pkt_i,
  input  logic [ptag_width_p-1:0]        ptag_i,
  input  logic                           pkt_v_i,
  output logic                           pkt_ready_o,
  output logic [pkt_width_p-1:0]         dcache_pkt_o,
  output logic                           dcache_v_o,
  input  logic                           dcache_ready_i,
  output logic [ptag_width_p-1:0]        dcache_ptag_o,
  output logic                           dcache_tlb_miss_o,
  input  logic                           done_i,
  input  logic                           rollback_i,
  output logic [replay_cnt_width_gp-1:0] replay_cnt_o
);

  localparam int unsigned idx_w = $clog2(els_p);
  localparam int unsigned ptr_w = idx_w + 1;
  localparam int unsigned ent_w = pkt_width_p + ptag_width_p;
  localparam int unsigned inj_w = (tlb_miss_period_p > 2) ? $clog2(tlb_miss_period_p) : 1;

  typedef logic [ptr_w-1:0] ptr_t;

  logic [ent_w-1:0]               mem_q [els_p];
  ptr_t                           wp_q, wp_d, rp_q, rp_d, cp_q, cp_d;
  logic [inj_w-1:0]               inj_q, inj_d;
  logic [ptag_width_p-1:0]        ptag_q, ptag_d;
  logic                           miss_q, miss_d;
  logic [replay_cnt_width_gp-1:0] replay_q, replay_d;
  logic [ent_w-1:0]               rd_ent;
  logic                           enq, issue, issue_eff, done_ok, inj_hit;

  assign rd_ent       = mem_q[rp_q[idx_w-1:0]];
  assign pkt_ready_o  = ptr_t'(wp_q - cp_q) != ptr_t'(els_p);
  assign dcache_v_o   = (rp_q != wp_q);
  assign dcache_pkt_o = rd_ent[pkt_width_p-1:0];

  assign enq       = pkt_v_i & pkt_ready_o;
  assign issue     = dcache_v_o & dcache_ready_i;
  assign issue_eff = issue & ~rollback_i;
  // A completion with nothing in flight is ignored rather than corrupting cp.
  assign done_ok   = done_i & (cp_q != rp_q);

  if (tlb_miss_period_p == 0) begin : g_no_inj
    assign inj_hit = 1'b0;
  end else begin : g_inj
    assign inj_hit = (inj_q == inj_w'(tlb_miss_period_p - 1));
  end

  // Pointer, mock-TLB and statistics next-state.
  always_comb begin
    wp_d     = wp_q + ptr_t'(enq);
    cp_d     = cp_q + ptr_t'(done_ok);
    rp_d     = rp_q + ptr_t'(issue);
    inj_d    = inj_q;
    ptag_d   = ptag_q;
    miss_d   = miss_q;
    replay_d = replay_q;
    if (rollback_i) begin
      rp_d     = cp_d;
      replay_d = sat_inc(replay_q);
    end
    if (issue_eff) begin
      ptag_d = rd_ent[ent_w-1 -: ptag_width_p];
      miss_d = inj_hit;
      inj_d  = inj_hit ? '0 : inj_q + inj_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cp_q     <= '0;
      inj_q    <= '0;
      ptag_q   <= '0;
      miss_q   <= 1'b0;
      replay_q <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cp_q     <= cp_d;
      inj_q    <= inj_d;
      ptag_q   <= ptag_d;
      miss_q   <= miss_d;
      replay_q <= replay_d;
    end
  end

  // Storage: registered write, asynchronous read at rp.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wp_q[idx_w-1:0]] <= {ptag_i, pkt_i};
    end
  end

  assign dcache_ptag_o     = ptag_q;
  assign dcache_tlb_miss_o = miss_q;
  assign replay_cnt_o      = replay_q;

  done_without_outstanding: assert property (
    @(posedge clk_i) disable iff (reset_i) !(done_i && (cp_q == rp_q))
  ) else $error("done_i asserted with no outstanding packet");

endmodule

// File: rtl/bp_be_dcache_replay_ctrl.sv
// Multi-channel dcache replay controller: one independent replay FIFO with
// mock TLB per dcache instance.
module bp_be_dcache_replay_ctrl
  import bp_be_dcache_replay_ctrl_pkg::*;
#(
  parameter int unsigned num_ch_p          = 2,
  parameter int unsigned pkt_width_p       = dcache_pkt_width_gp,
  parameter int unsigned ptag_width_p      = ptag_width_gp,
  parameter int unsigned els_p             = 8,
  parameter int unsigned tlb_miss_period_p = 0
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [num_ch_p*pkt_width_p-1:0]         pkt_i,
  input  logic [num_ch_p*ptag_width_p-1:0]        ptag_i,
  input  logic [num_ch_p-1:0]                     pkt_v_i,
  output logic [num_ch_p-1:0]                     pkt_ready_o,
  output logic [num_ch_p*pkt_width_p-1:0]         dcache_pkt_o,
  output logic [num_ch_p-1:0]                     dcache_v_o,
  input  logic [num_ch_p-1:0]                     dcache_ready_i,
  output logic [num_ch_p*ptag_width_p-1:0]        dcache_ptag_o,
  output logic [num_ch_p-1:0]                     dcache_tlb_miss_o,
  input  logic [num_ch_p-1:0]                     done_i,
  input  logic [num_ch_p-1:0]                     rollback_i,
  output logic [num_ch_p*replay_cnt_width_gp-1:0] replay_cnt_o
);

  for (genvar i = 0; i < num_ch_p; i++) begin : g_ch
    bp_be_replay_fifo #(
      .els_p            (els_p),
      .pkt_width_p      (pkt_width_p),
      .ptag_width_p     (ptag_width_p),
      .tlb_miss_period_p(tlb_miss_period_p)
    ) fifo (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .pkt_i            (pkt_i[i*pkt_width_p +: pkt_width_p]),
      .ptag_i           (ptag_i[i*ptag_width_p +: ptag_width_p]),
      .pkt_v_i          (pkt_v_i[i]),
      .pkt_ready_o      (pkt_ready_o[i]),
      .dcache_pkt_o     (dcache_pkt_o[i*pkt_width_p +: pkt_width_p]),
      .dcache_v_o       (dcache_v_o[i]),
      .dcache_ready_i   (dcache_ready_i[i]),
      .dcache_ptag_o    (dcache_ptag_o[i*ptag_width_p +: ptag_width_p]),
      .dcache_tlb_miss_o(dcache_tlb_miss_o[i]),
      .done_i           (done_i[i]),
      .rollback_i       (rollback_i[i]),
      .replay_cnt_o     (replay_cnt_o[i*replay_cnt_width_gp +: replay_cnt_width_gp])
    );
  end

endmodule
